// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//   Moore FSM that sequences the multicycle MIPS datapath. It owns every
//   datapath write enable, mux select and datapath reset. An instruction
//   takes 3 to 5 cycles through one shared ALU and one memory.
//
//   Outputs are registered. The next-state logic works out the state being
//   entered, and its control word is loaded alongside the state. The one
//   exception is the BEQ PC enable, which follows the live ALU zero flag in
//   the same cycle.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : ILLEGAL is terminal. halted=1 and all enables stay 0 until RST.
//   undefined : ILLEGAL is a one-cycle NOP that returns to FETCH. halted is 0.
//
// Ports
//   CLK                    in   rising-edge clock
//   RST                    in   asynchronous reset, active high
//   opcode[5:0]            in   IR[31:26]
//   funct[5:0]             in   IR[5:0]
//   zero                   in   ALU zero flag (combinational)
//   MWE, RFWE, PCE, IRWE   out  memory / RF / PC / IR write enables
//   MRST .. ALU_out_reg_RST out datapath register resets
//   ALU_sel[3:0]           out  ALU operation code
//   ALU_in_sel1[1:0]       out  0=PC 1=RF_out1_reg 2=shamt
//   ALU_in_sel2[1:0]       out  0=RF_out2_reg 1=const 1 2=Simm
//   PC_sel[1:0]            out  0=ALU_out 1=ALU_out_reg 2=jump target
//   M_to_RF_sel            out  RF write data (0=ALU reg, 1=DR)
//   RFD_sel                out  RF destination (0=rt, 1=rd)
//   ID_sel                 out  memory address (0=PC, 1=ALU reg)
//   halted                 out  core stopped on an illegal instruction
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter logic [3:0] ALU_ADD = 4'd0,
  parameter logic [3:0] ALU_SUB = 4'd1,
  parameter logic [3:0] ALU_AND = 4'd2,
  parameter logic [3:0] ALU_OR  = 4'd3,
  parameter logic [3:0] ALU_SLT = 4'd4,
  parameter logic [3:0] ALU_SLL = 4'd5,
  parameter logic [3:0] ALU_SRL = 4'd6,
  parameter logic [3:0] ALU_NOR = 4'd7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       MWE,
  output logic       RFWE,
  output logic       PCE,
  output logic       IRWE,
  output logic       MRST,
  output logic       RFRST,
  output logic       PCRRST,
  output logic       IRRST,
  output logic       DRRST,
  output logic       RF_out1_reg_RST,
  output logic       RF_out2_reg_RST,
  output logic       ALU_out_reg_RST,
  output logic [3:0] ALU_sel,
  output logic [1:0] ALU_in_sel1,
  output logic [1:0] ALU_in_sel2,
  output logic [1:0] PC_sel,
  output logic       M_to_RF_sel,
  output logic       RFD_sel,
  output logic       ID_sel,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_RTYPE, S_RWB, S_MEMADR, S_LW, S_LWB,
    S_SW, S_ADDI, S_IWB, S_BEQ, S_JUMP, S_ILLEGAL
  } state_t;

  // Full control word for one state.
  // beqGate lets the live zero flag drive PCE while the FSM sits in BEQ.
  typedef struct packed {
    logic       mwe;
    logic       rfwe;
    logic       pce;
    logic       irwe;
    logic [7:0] rsts;
    logic [3:0] aluSel;
    logic [1:0] in1;
    logic [1:0] in2;
    logic [1:0] pcSel;
    logic       mToRf;
    logic       rfd;
    logic       id;
    logic       halted;
    logic       beqGate;
  } ctrl_t;

  localparam ctrl_t RESET_CTRL = '{rsts: 8'hFF, default: '0};

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  function automatic logic rtypeKnown(input logic [5:0] f);
    case (f)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00, 6'h02: rtypeKnown = 1'b1;
      default:                                                 rtypeKnown = 1'b0;
    endcase
  endfunction

  function automatic ctrl_t decodeState(input state_t s, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (s)
      S_RST:    c.rsts = 8'hFF;
      S_FETCH: begin
        c.irwe = 1'b1;
        c.pce  = 1'b1;
        c.in2  = 2'd1;
        c.aluSel = ALU_ADD;
      end
      S_DECODE: begin
        c.in2    = 2'd2;
        c.aluSel = ALU_ADD;
      end
      S_RTYPE: begin
        c.in1 = 2'd1;
        case (f)
          6'h20: c.aluSel = ALU_ADD;
          6'h22: c.aluSel = ALU_SUB;
          6'h24: c.aluSel = ALU_AND;
          6'h25: c.aluSel = ALU_OR;
          6'h2A: c.aluSel = ALU_SLT;
          6'h27: c.aluSel = ALU_NOR;
          // Shifts take the shift amount from the instruction, not rs.
          6'h00: begin c.aluSel = ALU_SLL; c.in1 = 2'd2; end
          6'h02: begin c.aluSel = ALU_SRL; c.in1 = 2'd2; end
          default: c.aluSel = ALU_ADD;
        endcase
      end
      S_RWB: begin
        c.rfwe = 1'b1;
        c.rfd  = 1'b1;
      end
      S_MEMADR, S_ADDI: begin
        c.in1    = 2'd1;
        c.in2    = 2'd2;
        c.aluSel = ALU_ADD;
      end
      S_LW:     c.id = 1'b1;
      S_LWB: begin
        c.rfwe  = 1'b1;
        c.mToRf = 1'b1;
      end
      S_SW: begin
        c.id  = 1'b1;
        c.mwe = 1'b1;
      end
      S_IWB:    c.rfwe = 1'b1;
      S_BEQ: begin
        c.in1     = 2'd1;
        c.aluSel  = ALU_SUB;
        c.pcSel   = 2'd1;
        c.beqGate = 1'b1;
      end
      S_JUMP: begin
        c.pcSel = 2'd2;
        c.pce   = 1'b1;
      end
      S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        c.halted = 1'b1;
`endif
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic. The control word for the state being entered is
  // computed here so that it is registered together with the state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h00:        state_d = rtypeKnown(funct) ? S_RTYPE : S_ILLEGAL;
          6'h23, 6'h2B: state_d = S_MEMADR;
          6'h04:        state_d = S_BEQ;
          6'h08:        state_d = S_ADDI;
          6'h02:        state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_RTYPE:  state_d = S_RWB;
      S_MEMADR: state_d = (opcode == 6'h23) ? S_LW : S_SW;
      S_LW:     state_d = S_LWB;
      S_ADDI:   state_d = S_IWB;
      S_RWB, S_LWB, S_SW, S_IWB, S_BEQ, S_JUMP: state_d = S_FETCH;
      S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_ILLEGAL;
`else
        state_d = S_FETCH;
`endif
      end
      default:  state_d = S_RST;
    endcase
    ctrl_d = decodeState(state_d, funct);
  end

  // State and registered control word. Reset forces S_RST immediately and
  // cancels any pending RF or memory write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_RST;
      ctrl_q  <= RESET_CTRL;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign MWE             = ctrl_q.mwe;
  assign RFWE            = ctrl_q.rfwe;
  assign PCE             = ctrl_q.pce | (ctrl_q.beqGate & zero);
  assign IRWE            = ctrl_q.irwe;
  assign MRST            = ctrl_q.rsts[7];
  assign RFRST           = ctrl_q.rsts[6];
  assign PCRRST          = ctrl_q.rsts[5];
  assign IRRST           = ctrl_q.rsts[4];
  assign DRRST           = ctrl_q.rsts[3];
  assign RF_out1_reg_RST = ctrl_q.rsts[2];
  assign RF_out2_reg_RST = ctrl_q.rsts[1];
  assign ALU_out_reg_RST = ctrl_q.rsts[0];
  assign ALU_sel         = ctrl_q.aluSel;
  assign ALU_in_sel1     = ctrl_q.in1;
  assign ALU_in_sel2     = ctrl_q.in2;
  assign PC_sel          = ctrl_q.pcSel;
  assign M_to_RF_sel     = ctrl_q.mToRf;
  assign RFD_sel         = ctrl_q.rfd;
  assign ID_sel          = ctrl_q.id;
  assign halted          = ctrl_q.halted;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//   Directed bench for multicycle_controller. Every output is packed into
//   one observation vector and compared once per cycle, on the falling
//   edge, against hand-written expected control words.
//   Follows ILLEGAL_TRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct  = 6'h20;
  logic       zero   = 1'b0;
  logic       MWE, RFWE, PCE, IRWE;
  logic       MRST, RFRST, PCRRST, IRRST, DRRST;
  logic       RF_out1_reg_RST, RF_out2_reg_RST, ALU_out_reg_RST;
  logic [3:0] ALU_sel;
  logic [1:0] ALU_in_sel1, ALU_in_sel2, PC_sel;
  logic       M_to_RF_sel, RFD_sel, ID_sel, halted;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct), .zero(zero),
    .MWE(MWE), .RFWE(RFWE), .PCE(PCE), .IRWE(IRWE),
    .MRST(MRST), .RFRST(RFRST), .PCRRST(PCRRST), .IRRST(IRRST), .DRRST(DRRST),
    .RF_out1_reg_RST(RF_out1_reg_RST), .RF_out2_reg_RST(RF_out2_reg_RST),
    .ALU_out_reg_RST(ALU_out_reg_RST),
    .ALU_sel(ALU_sel), .ALU_in_sel1(ALU_in_sel1), .ALU_in_sel2(ALU_in_sel2),
    .PC_sel(PC_sel), .M_to_RF_sel(M_to_RF_sel), .RFD_sel(RFD_sel),
    .ID_sel(ID_sel), .halted(halted)
  );

  always #5 CLK = ~CLK;

  // Observation order: MWE RFWE PCE IRWE | 8 resets | ALU_sel | sel1 | sel2 |
  // PC_sel | M_to_RF_sel RFD_sel ID_sel halted
  logic [25:0] obs;
  assign obs = {MWE, RFWE, PCE, IRWE,
                MRST, RFRST, PCRRST, IRRST, DRRST,
                RF_out1_reg_RST, RF_out2_reg_RST, ALU_out_reg_RST,
                ALU_sel, ALU_in_sel1, ALU_in_sel2, PC_sel,
                M_to_RF_sel, RFD_sel, ID_sel, halted};

  function automatic logic [25:0] expv(
    input logic mwe, input logic rfwe, input logic pce, input logic irwe,
    input logic [7:0] rsts, input logic [3:0] alu,
    input logic [1:0] in1, input logic [1:0] in2, input logic [1:0] pcs,
    input logic m2r, input logic rfd, input logic id, input logic halt);
    return {mwe, rfwe, pce, irwe, rsts, alu, in1, in2, pcs, m2r, rfd, id, halt};
  endfunction

  // Hand-written control words for the states visited below.
  logic [25:0] E_RST, E_FETCH, E_DECODE, E_ZERO;
  initial begin
    E_RST    = expv(0,0,0,0, 8'hFF, 4'd0, 2'd0, 2'd0, 2'd0, 0,0,0,0);
    E_FETCH  = expv(0,0,1,1, 8'h00, 4'd0, 2'd0, 2'd1, 2'd0, 0,0,0,0);
    E_DECODE = expv(0,0,0,0, 8'h00, 4'd0, 2'd0, 2'd2, 2'd0, 0,0,0,0);
    E_ZERO   = '0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic z);
    opcode = op;
    funct  = fn;
    zero   = z;
  endtask

  // Advance to the next falling edge and compare the whole control word.
  task automatic stepCheck(input string tag, input logic [25:0] expected);
    @(negedge CLK);
    checkOutput(tag, {6'd0, obs}, {6'd0, expected});
  endtask

  initial begin
    // Reset held, then released between edges: still S_RST until next edge.
    applyStimulus(6'h00, 6'h20, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("rst.hold", {6'd0, obs}, {6'd0, E_RST});
    RST = 1'b0;
    #1;
    checkOutput("rst.after", {6'd0, obs}, {6'd0, E_RST});

    // add $3,$1,$2
    stepCheck("add.fetch", E_FETCH);
    stepCheck("add.decode", E_DECODE);
    stepCheck("add.rtype", expv(0,0,0,0, 8'h00, 4'd0, 2'd1, 2'd0, 2'd0, 0,0,0,0));
    stepCheck("add.rwb",   expv(0,1,0,0, 8'h00, 4'd0, 2'd0, 2'd0, 2'd0, 0,1,0,0));

    // lw 0x8C220004
    stepCheck("lw.fetch", E_FETCH);
    applyStimulus(6'h23, 6'h04, 1'b0);
    stepCheck("lw.decode", E_DECODE);
    stepCheck("lw.memadr", expv(0,0,0,0, 8'h00, 4'd0, 2'd1, 2'd2, 2'd0, 0,0,0,0));
    stepCheck("lw.lw",     expv(0,0,0,0, 8'h00, 4'd0, 2'd0, 2'd0, 2'd0, 0,0,1,0));
    stepCheck("lw.lwb",    expv(0,1,0,0, 8'h00, 4'd0, 2'd0, 2'd0, 2'd0, 1,0,0,0));

    // sw 0xAC220004
    stepCheck("sw.fetch", E_FETCH);
    applyStimulus(6'h2B, 6'h04, 1'b0);
    stepCheck("sw.decode", E_DECODE);
    stepCheck("sw.memadr", expv(0,0,0,0, 8'h00, 4'd0, 2'd1, 2'd2, 2'd0, 0,0,0,0));
    stepCheck("sw.sw",     expv(1,0,0,0, 8'h00, 4'd0, 2'd0, 2'd0, 2'd0, 0,0,1,0));

    // beq taken: zero=1
    stepCheck("beq1.fetch", E_FETCH);
    applyStimulus(6'h04, 6'h00, 1'b1);
    stepCheck("beq1.decode", E_DECODE);
    stepCheck("beq1.beq", expv(0,0,1,0, 8'h00, 4'd1, 2'd1, 2'd0, 2'd1, 0,0,0,0));

    // beq not taken: zero=0
    stepCheck("beq0.fetch", E_FETCH);
    applyStimulus(6'h04, 6'h00, 1'b0);
    stepCheck("beq0.decode", E_DECODE);
    stepCheck("beq0.beq", expv(0,0,0,0, 8'h00, 4'd1, 2'd1, 2'd0, 2'd1, 0,0,0,0));

    // j
    stepCheck("j.fetch", E_FETCH);
    applyStimulus(6'h02, 6'h00, 1'b0);
    stepCheck("j.decode", E_DECODE);
    stepCheck("j.jump", expv(0,0,1,0, 8'h00, 4'd0, 2'd0, 2'd0, 2'd2, 0,0,0,0));

    // sll
    stepCheck("sll.fetch", E_FETCH);
    applyStimulus(6'h00, 6'h00, 1'b0);
    stepCheck("sll.decode", E_DECODE);
    stepCheck("sll.rtype", expv(0,0,0,0, 8'h00, 4'd5, 2'd2, 2'd0, 2'd0, 0,0,0,0));
    stepCheck("sll.rwb",   expv(0,1,0,0, 8'h00, 4'd0, 2'd0, 2'd0, 2'd0, 0,1,0,0));

    // addi
    stepCheck("addi.fetch", E_FETCH);
    applyStimulus(6'h08, 6'h05, 1'b0);
    stepCheck("addi.decode", E_DECODE);
    stepCheck("addi.addi", expv(0,0,0,0, 8'h00, 4'd0, 2'd1, 2'd2, 2'd0, 0,0,0,0));
    stepCheck("addi.iwb",  expv(0,1,0,0, 8'h00, 4'd0, 2'd0, 2'd0, 2'd0, 0,0,0,0));

    // Illegal opcode 0x3F
    stepCheck("ill.fetch", E_FETCH);
    applyStimulus(6'h3F, 6'h00, 1'b1);
    stepCheck("ill.decode", E_DECODE);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++)
      stepCheck("ill.halt", expv(0,0,0,0, 8'h00, 4'd0, 2'd0, 2'd0, 2'd0, 0,0,0,1));
    RST = 1'b1;
    #1;
    checkOutput("ill.clear", {6'd0, obs}, {6'd0, E_RST});
    @(negedge CLK);
    RST = 1'b0;
`else
    stepCheck("ill.nop", E_ZERO);
`endif
    stepCheck("ill.next", E_FETCH);

    // Reset in the middle of an add: the RWB write must never appear.
    applyStimulus(6'h00, 6'h25, 1'b0);
    stepCheck("abort.decode", E_DECODE);
    stepCheck("abort.rtype", expv(0,0,0,0, 8'h00, 4'd3, 2'd1, 2'd0, 2'd0, 0,0,0,0));
    RST = 1'b1;
    #1;
    checkOutput("abort.async", {6'd0, obs}, {6'd0, E_RST});
    stepCheck("abort.held", E_RST);
    RST = 1'b0;
    stepCheck("abort.fetch", E_FETCH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
